// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared constants and the fill-state type for the cache fill FSM.
// Revision : 1.0  initial release
// ============================================================================
package cache_pkg;

   localparam int BLOCK_WORDS = 8;
   localparam int WORD_OFF_W  = 3;

   // Clears the byte-within-block bits of a 16-bit address
   localparam logic [15:0] c_BLOCK_MASK = 16'hFFF0;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm_if
// Purpose  : Miss, main-memory and cache-array signals of one fill controller.
// Revision : 1.0  initial release
// ============================================================================
interface cache_fill_fsm_if #(
   parameter int ADDR_W = 16,
   parameter int OFF_W  = 3
);
   import cache_pkg::*;

   logic              miss_detected;
   logic [ADDR_W-1:0] miss_address;
   logic              fsm_busy;
   logic              mem_enable;
   logic [ADDR_W-1:0] memory_address;
   logic              memory_valid;
   logic [15:0]       memory_data_in;
   logic              write_data_array;
   logic              write_tag_array;
   logic [OFF_W-1:0]  word_offset;
   logic [15:0]       data_out;

   modport master (
      input  miss_detected,
      input  miss_address,
      input  memory_valid,
      input  memory_data_in,
      output fsm_busy,
      output mem_enable,
      output memory_address,
      output write_data_array,
      output write_tag_array,
      output word_offset,
      output data_out
   );

   modport slave (
      output miss_detected,
      output miss_address,
      output memory_valid,
      output memory_data_in,
      input  fsm_busy,
      input  mem_enable,
      input  memory_address,
      input  write_data_array,
      input  write_tag_array,
      input  word_offset,
      input  data_out
   );

endinterface
`default_nettype wire

// File: rtl/cache_fill_fsm_fill_counter.sv
`default_nettype none
// ============================================================================
// Module   : fill_counter
// Purpose  : Word counter with synchronous clear and increment enable.
// Revision : 1.0  initial release
// ============================================================================
module fill_counter #(
   parameter int WIDTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_clr,
   input  wire logic             i_inc,
   output logic      [WIDTH-1:0] o_cnt
);
   import cache_pkg::*;

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : Cache-miss block fill: one read per cycle, data/tag array writes.
//            Macro FILL_CRITICAL_WORD_FIRST_EN starts the fill at the missed word.
// Revision : 1.0  initial release
// ============================================================================
module cache_fill_fsm #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   cache_fill_fsm_if.master  bus
);
   import cache_pkg::*;

   localparam int                c_OFF_W     = $clog2(BLOCK_WORDS);
   localparam int                c_CNT_W     = c_OFF_W + 1;
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(BLOCK_WORDS);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLOCK_WORDS - 1);
   localparam logic [ADDR_W-1:0]  c_BASE_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);

   fill_state_t         r_state;
   fill_state_t         w_next;
   logic [ADDR_W-1:0]   r_base;
   logic [c_OFF_W-1:0]  w_start;
   logic [c_CNT_W-1:0]  w_req_cnt;
   logic [c_CNT_W-1:0]  w_rcv_cnt;
   logic                w_start_fill;
   logic                w_req_pend;
   logic                w_rcv_inc;
   logic                w_last_rcv;
   logic [c_OFF_W-1:0]  w_req_idx;
   logic [c_OFF_W-1:0]  w_rcv_idx;

   assign w_start_fill = (r_state == IDLE) && bus.miss_detected;
   assign w_req_pend   = (r_state == FILL) && (w_req_cnt < c_CNT_FULL);
   assign w_rcv_inc    = (r_state == FILL) && bus.memory_valid;
   assign w_last_rcv   = w_rcv_inc && (w_rcv_cnt == c_CNT_LAST);

   fill_counter #(.WIDTH(c_CNT_W)) u_req_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_start_fill),
      .i_inc (w_req_pend),
      .o_cnt (w_req_cnt)
   );

   fill_counter #(.WIDTH(c_CNT_W)) u_rcv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_start_fill),
      .i_inc (w_rcv_inc),
      .o_cnt (w_rcv_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base <= '0;
      end else if (w_start_fill) begin
         r_base <= bus.miss_address & c_BASE_MASK;
      end
   end

`ifdef FILL_CRITICAL_WORD_FIRST_EN
   logic [c_OFF_W-1:0] r_start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start <= '0;
      end else if (w_start_fill) begin
         r_start <= bus.miss_address[c_OFF_W:1];
      end
   end

   assign w_start = r_start;
`else
   assign w_start = '0;
`endif

   // Word indices wrap modulo the block size by truncation
   assign w_req_idx = w_start + w_req_cnt[c_OFF_W-1:0];
   assign w_rcv_idx = w_start + w_rcv_cnt[c_OFF_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.miss_detected) w_next = FILL;
         FILL:    if (w_last_rcv)        w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.fsm_busy         = 1'b0;
      bus.mem_enable       = 1'b0;
      bus.memory_address   = '0;
      bus.write_data_array = 1'b0;
      bus.write_tag_array  = 1'b0;
      bus.word_offset      = '0;
      if (r_state == FILL) begin
         bus.fsm_busy         = 1'b1;
         bus.word_offset      = w_rcv_idx;
         bus.write_data_array = bus.memory_valid;
         bus.write_tag_array  = w_last_rcv;
         if (w_req_pend) begin
            bus.mem_enable     = 1'b1;
            bus.memory_address = r_base + ADDR_W'({w_req_idx, 1'b0});
         end
      end
   end

   assign bus.data_out = bus.memory_data_in;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_fsm
// Purpose  : Directed self-checking bench for cache_fill_fsm with a latency memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_fill_fsm;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
   localparam bit c_CWF = 1'b1;
`else
   localparam bit c_CWF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   cache_fill_fsm_if #(.ADDR_W(16), .OFF_W(3)) bus ();

   cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Cycle 0 presents the miss; the memory answers each request lat(+gap) cycles later.
   task automatic run_fill(input logic [15:0] maddr, input int lat, input int gapmax,
                           input bit hold_miss, input int abort_at, input bit timed);
      logic [15:0] base;
      logic [15:0] exp_a;
      logic [15:0] vdata;
      logic [15:0] aq[$];
      int          dq[$];
      int          c, nreq, nrcv, last_due, d, start;
      bit          v;
      base  = maddr & 16'hFFF0;
      start = c_CWF ? int'(maddr[3:1]) : 0;
      bus.miss_detected  = 1'b1;
      bus.miss_address   = maddr;
      bus.memory_valid   = 1'b0;
      bus.memory_data_in = 16'h0000;
      #3;
      chk("idle_busy", bus.fsm_busy, 1'b0);
      chk("idle_men", bus.mem_enable, 1'b0);
      next_cycle();
      bus.miss_detected = hold_miss;
      bus.miss_address  = maddr ^ 16'h0F0E;
      c = 1; nreq = 0; nrcv = 0; last_due = 0;
      while (nrcv < 8) begin
         v = (dq.size() > 0) && (dq[0] == c);
         if (v) begin
            vdata = aq.pop_front() ^ 16'hA5A5;
            void'(dq.pop_front());
         end else begin
            vdata = 16'h0000;
         end
         bus.memory_valid   = v;
         bus.memory_data_in = vdata;
         #4;
         chk("busy", bus.fsm_busy, 1'b1);
         if (nreq < 8) begin
            exp_a = base + 16'(((start + nreq) % 8) * 2);
            chk("men", bus.mem_enable, 1'b1);
            chk("addr", bus.memory_address, exp_a);
            if (timed) chk("req_cyc", c, nreq + 1);
            d = c + lat + ((gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            dq.push_back(d);
            aq.push_back(exp_a);
            nreq++;
         end else begin
            chk("men_off", bus.mem_enable, 1'b0);
         end
         chk("wda", bus.write_data_array, v);
         if (v) begin
            chk("woff", bus.word_offset, (start + nrcv) % 8);
            chk("dout", bus.data_out, vdata);
            chk("wta", bus.write_tag_array, (nrcv == 7));
            if (timed) chk("rcv_cyc", c, nrcv + 1 + lat);
            nrcv++;
         end else begin
            chk("wta_gap", bus.write_tag_array, 1'b0);
         end
         if (abort_at > 0 && nrcv == abort_at) begin
            next_cycle();
            rst_n = 1'b0;
            bus.memory_valid   = 1'b1;
            bus.memory_data_in = 16'hBEEF;
            #1;
            chk("rst_busy", bus.fsm_busy, 1'b0);
            chk("rst_men", bus.mem_enable, 1'b0);
            chk("rst_addr", bus.memory_address, 16'h0000);
            chk("rst_wda", bus.write_data_array, 1'b0);
            chk("rst_wta", bus.write_tag_array, 1'b0);
            chk("rst_woff", bus.word_offset, 3'd0);
            chk("rst_dout", bus.data_out, 16'hBEEF);
            next_cycle();
            chk("rst_wta_hold", bus.write_tag_array, 1'b0);
            rst_n = 1'b1;
            bus.memory_valid  = 1'b0;
            bus.miss_detected = 1'b0;
            next_cycle();
            chk("rst_idle", bus.fsm_busy, 1'b0);
            return;
         end
         if (nrcv < 8) begin
            next_cycle();
            c++;
         end
         if (c > 200) begin
            chk("timeout", c, 0);
            return;
         end
      end
      if (timed) chk("tag_cyc", c, lat + 8);
      next_cycle();
      bus.miss_detected  = hold_miss;
      bus.memory_valid   = 1'b0;
      bus.memory_data_in = 16'h0000;
      #4;
      chk("busy_fall", bus.fsm_busy, 1'b0);
      chk("men_after", bus.mem_enable, 1'b0);
   endtask

   initial begin
      #200000;
      chk("watchdog", 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.miss_detected  = 1'b0;
      bus.miss_address   = 16'h0000;
      bus.memory_valid   = 1'b0;
      bus.memory_data_in = 16'h5A5A;
      #3;
      chk("res_busy", bus.fsm_busy, 1'b0);
      chk("res_men", bus.mem_enable, 1'b0);
      chk("res_addr", bus.memory_address, 16'h0000);
      chk("res_wda", bus.write_data_array, 1'b0);
      chk("res_wta", bus.write_tag_array, 1'b0);
      chk("res_woff", bus.word_offset, 3'd0);
      chk("res_dout", bus.data_out, 16'h5A5A);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // Fixed latency 4: exact cycle placement of requests, returns and tag write
      run_fill(16'h1236, 4, 0, 1'b0, 0, 1'b1);

      // A stray valid in IDLE must not write anything
      next_cycle();
      bus.memory_valid   = 1'b1;
      bus.memory_data_in = 16'h1234;
      #4;
      chk("stray_wda", bus.write_data_array, 1'b0);
      chk("stray_wta", bus.write_tag_array, 1'b0);
      chk("stray_busy", bus.fsm_busy, 1'b0);
      chk("stray_dout", bus.data_out, 16'h1234);
      next_cycle();
      bus.memory_valid = 1'b0;
      next_cycle();

      // Random gaps between returns
      run_fill(16'h2468, 3, 3, 1'b0, 0, 1'b0);
      next_cycle();

      // Miss held high through two fills: back-to-back, no restart mid-fill
      run_fill(16'h4000, 2, 0, 1'b1, 0, 1'b1);
      run_fill(16'h400C, 2, 0, 1'b1, 0, 1'b1);
      bus.miss_detected = 1'b0;
      next_cycle();
      chk("no_third", bus.fsm_busy, 1'b0);

      // Reset after the 5th data write, then a clean fill from word 0
      run_fill(16'h7770, 4, 0, 1'b0, 5, 1'b0);
      run_fill(16'h7770, 4, 0, 1'b0, 0, 1'b1);
      next_cycle();

      // Top of the address space: no wrap past 0xFFFF
      run_fill(16'hFFFA, 4, 0, 1'b0, 0, 1'b1);
      next_cycle();

      // Mid-block miss (critical word first when enabled)
      run_fill(16'h123A, 1, 2, 1'b0, 0, 1'b0);
      next_cycle();
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
